systolic_array_controller: RTL

Sequencing controller for an N×N grid of signed processing elements (PEs) in the matrix-multiply datapath. It accepts a start command with a mode (output-stationary or weight-stationary) and an inner dimension K. It then steps the array through clear/load, skewed streaming and drain phases by driving the PE control lines and per-lane operand feed enables. It sits between the host/command logic and the PE grid plus its edge operand buffers.

---
 rtl/systolic_array_controller_if.sv | 32 +++
 rtl/systolic_array_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/systolic_array_controller_if.sv
// rtl/systolic_array_controller_if.sv - command and PE-control bundle for the systolic array controller
interface systolic_array_controller_if #(
    parameter int N  = 4,
    parameter int KW = 8
);
    logic          start_i;
    logic          mode_os_i;
    logic [KW-1:0] k_i;
    logic          busy_o;
    logic          done_o;
    logic          ctrl_out_stat_o;
    logic          ctrl_load_o;
    logic          ctrl_sum_out_o;
    logic          ctrl_ps_in_o;
    logic          ctrl_ps_valid_o;
    logic          zero_opnd_o;
    logic          wload_o;
    logic [N-1:0]  feed_en_o;
    logic          drain_o;

    modport master (
        output start_i, mode_os_i, k_i,
        input  busy_o, done_o, ctrl_out_stat_o, ctrl_load_o, ctrl_sum_out_o,
        input  ctrl_ps_in_o, ctrl_ps_valid_o, zero_opnd_o, wload_o, feed_en_o, drain_o
    );

    modport slave (
        input  start_i, mode_os_i, k_i,
        output busy_o, done_o, ctrl_out_stat_o, ctrl_load_o, ctrl_sum_out_o,
        output ctrl_ps_in_o, ctrl_ps_valid_o, zero_opnd_o, wload_o, feed_en_o, drain_o
    );
endinterface

// File: rtl/systolic_array_controller.sv
// rtl/systolic_array_controller.sv - phase sequencer (clear/load, skewed stream, drain) for an NxN PE grid
module systolic_array_controller #(
    parameter int N  = 4,
    parameter int KW = 8
) (
    input logic                        clk_i,
    input logic                        rstn_i,
    systolic_array_controller_if.slave bus
);
    localparam int CW = $clog2((1 << KW) + 2 * N);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [KW-1:0] r_k;
    logic          r_mode;
    logic          r_busy;
    logic          r_done;
    logic          r_load;
    logic          r_sum_out;
    logic          r_ps_in;
    logic          r_ps_valid;
    logic          r_zero;
    logic          r_wload;
    logic          r_drain;
    logic [N-1:0]  r_feed;

    logic [CW-1:0] w_s_last;
    logic [CW-1:0] w_c_next;
    logic [N-1:0]  w_mask;

    // Last stream index S-1 = K + 2N - 3; the lane mask is computed for the cycle being entered.
    assign w_s_last = CW'(r_k) + CW'(2 * N - 3);
    assign w_c_next = (r_state == S_STREAM) ? r_cnt + 1'b1 : '0;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (w_c_next >= CW'(i)) && (w_c_next < CW'(i) + CW'(r_k));
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_k        <= '0;
            r_mode     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_load     <= 1'b0;
            r_sum_out  <= 1'b0;
            r_ps_in    <= 1'b0;
            r_ps_valid <= 1'b0;
            r_zero     <= 1'b0;
            r_wload    <= 1'b0;
            r_drain    <= 1'b0;
            r_feed     <= '0;
        end else begin
            r_done     <= 1'b0;
            r_load     <= 1'b0;
            r_sum_out  <= 1'b0;
            r_ps_in    <= 1'b0;
            r_ps_valid <= 1'b0;
            r_zero     <= 1'b0;
            r_wload    <= 1'b0;
            r_drain    <= 1'b0;
            r_feed     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i && (bus.k_i != '0)) begin
                        r_mode <= bus.mode_os_i;
                        r_k    <= bus.k_i;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (bus.mode_os_i) begin
                            r_state    <= S_CLEAR;
                            r_ps_valid <= 1'b1;
                            r_zero     <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_load  <= 1'b1;
                            r_wload <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    r_state    <= S_STREAM;
                    r_cnt      <= '0;
                    r_ps_in    <= 1'b1;
                    r_ps_valid <= 1'b1;
                    r_feed     <= w_mask;
                    r_zero     <= ~&w_mask;
                end
                S_LOAD: begin
                    if (r_cnt == CW'(N - 1)) begin
                        r_state   <= S_STREAM;
                        r_cnt     <= '0;
                        r_sum_out <= 1'b1;
                        r_drain   <= 1'b1;
                        r_feed    <= w_mask;
                        r_zero    <= ~&w_mask;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_load  <= 1'b1;
                        r_wload <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (r_cnt == w_s_last) begin
                        r_cnt <= '0;
                        if (r_mode) begin
                            r_state   <= S_DRAIN;
                            r_sum_out <= 1'b1;
                            r_ps_in   <= 1'b1;
                            r_drain   <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        r_ps_in    <= r_mode;
                        r_ps_valid <= r_mode;
                        r_sum_out  <= ~r_mode;
                        r_drain    <= ~r_mode;
                        r_feed     <= w_mask;
                        r_zero     <= ~&w_mask;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_sum_out <= 1'b1;
                        r_ps_in   <= 1'b1;
                        r_drain   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o          = r_busy;
    assign bus.done_o          = r_done;
    assign bus.ctrl_out_stat_o = r_mode;
    assign bus.ctrl_load_o     = r_load;
    assign bus.ctrl_sum_out_o  = r_sum_out;
    assign bus.ctrl_ps_in_o    = r_ps_in;
    assign bus.ctrl_ps_valid_o = r_ps_valid;
    assign bus.zero_opnd_o     = r_zero;
    assign bus.wload_o         = r_wload;
    assign bus.feed_en_o       = r_feed;
    assign bus.drain_o         = r_drain;
endmodule
